snake_game_ctrl: RTL

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

---
 rtl/snake_game_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_game_ctrl.sv
// Purpose : game-flow controller for a snake game: IDLE/RUN/PAUSE/OVER FSM,
//           food-edge "eaten" pulse and a score-scaled move-tick generator.
// Latency : every output is registered; reactions appear one clk after the
//           triggering input is sampled (start/pause/food_hit edge, collision).
// Backpressure: none; level inputs are sampled every cycle, pulses are fire-and-forget.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, pause        level inputs; rising edges drive the FSM
//   food_hit, collision level inputs from the playfield logic
//   score[15:0]         current score, used to shorten the move-tick period
//   counter_reset       high while in IDLE (clears score/length counter)
//   eaten               one-cycle pulse per food_hit rising edge seen in RUN
//   game_over           high while in OVER
//   move_tick           one-cycle pulse each move period while running
//   state[1:0]          IDLE=0, RUN=1, PAUSE=2, OVER=3
//
// Build option: define SNAKE_PAUSE_EN to include the PAUSE state and the pause
// edge detector. Without it the pause input is ignored and state 2 is never used.

module snake_game_ctrl #(
    parameter int unsigned TICK_BASE = 50_000_000,
    parameter int unsigned TICK_STEP = 1_000_000,
    parameter int unsigned TICK_MIN  = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        food_hit,
    input  logic        collision,
    input  logic [15:0] score,
    output logic        counter_reset,
    output logic        eaten,
    output logic        game_over,
    output logic        move_tick,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // A zero minimum would make period-1 wrap, so the floor is at least 1.
    localparam logic [31:0] BASE_C = TICK_BASE;
    localparam logic [31:0] STEP_C = TICK_STEP;
    localparam logic [31:0] MIN_C  = (TICK_MIN == 0) ? 32'd1 : TICK_MIN;
    // How much the period may shrink before hitting the floor.
    localparam logic [31:0] HEADROOM_C = (BASE_C > MIN_C) ? (BASE_C - MIN_C) : 32'd0;

    state_t      state_q, state_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [31:0] period_q, period_d;
    logic        start_q, food_q;
    logic        counter_reset_q, counter_reset_d;
    logic        eaten_q, eaten_d;
    logic        game_over_q, game_over_d;
    logic        move_tick_q, move_tick_d;

    logic        start_edge;
    logic        food_edge;
    logic        pause_edge;
    logic        tick_wrap;
    logic [47:0] reduction;
    logic [31:0] period_calc;

`ifdef SNAKE_PAUSE_EN
    logic        pause_q;
    assign pause_edge = pause & ~pause_q;
`else
    // Pause is not part of this build; keep the port but discard it.
    logic        unused_pause;
    assign unused_pause = pause;
    assign pause_edge   = 1'b0;
`endif

    assign start_edge = start & ~start_q;
    assign food_edge  = food_hit & ~food_q;
    assign tick_wrap  = (tick_cnt_q == (period_q - 32'd1));

    // Period = max(MIN, BASE - STEP*score). The product is formed 48 bits wide
    // so a large score cannot wrap it back into the valid range; anything that
    // would reach or pass the floor saturates to MIN.
    always_comb begin
        reduction = {16'd0, STEP_C} * {32'd0, score};
        if (reduction >= {16'd0, HEADROOM_C}) begin
            period_calc = MIN_C;
        end else begin
            period_calc = BASE_C - reduction[31:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        period_d    = period_q;
        eaten_d     = 1'b0;
        move_tick_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                if (start_edge) begin
                    state_d  = ST_RUN;
                    // Score is latched here so the first period reflects it.
                    period_d = period_calc;
                end
            end

            ST_RUN: begin
                if (collision) begin
                    // Collision wins over food and pause: no eaten, no tick.
                    state_d    = ST_OVER;
                    tick_cnt_d = '0;
                end else begin
                    eaten_d = food_edge;
                    if (pause_edge) begin
                        state_d = ST_PAUSE;
                    end
                    // The counter still advances in the cycle the pause edge
                    // is seen; it freezes from the first PAUSE cycle onward.
                    if (tick_wrap) begin
                        tick_cnt_d  = '0;
                        move_tick_d = 1'b1;
                        period_d    = period_calc;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 32'd1;
                    end
                end
            end

            ST_PAUSE: begin
`ifdef SNAKE_PAUSE_EN
                // Counter and period hold; collision is ignored here.
                if (pause_edge) begin
                    state_d = ST_RUN;
                end
`else
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
`endif
            end

            ST_OVER: begin
                tick_cnt_d = '0;
                if (start_edge) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
            end
        endcase

        // Level outputs track the state being entered so they line up with state.
        counter_reset_d = (state_d == ST_IDLE);
        game_over_d     = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            tick_cnt_q      <= '0;
            period_q        <= BASE_C;
            start_q         <= 1'b0;
            food_q          <= 1'b0;
            counter_reset_q <= 1'b1;
            eaten_q         <= 1'b0;
            game_over_q     <= 1'b0;
            move_tick_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            period_q        <= period_d;
            start_q         <= start;
            food_q          <= food_hit;
            counter_reset_q <= counter_reset_d;
            eaten_q         <= eaten_d;
            game_over_q     <= game_over_d;
            move_tick_q     <= move_tick_d;
        end
    end

`ifdef SNAKE_PAUSE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause;
        end
    end
`endif

    assign state         = state_q;
    assign counter_reset = counter_reset_q;
    assign eaten         = eaten_q;
    assign game_over     = game_over_q;
    assign move_tick     = move_tick_q;

endmodule
